// File: rtl/cache_mem_arbiter.sv
// Two-requester cache-miss arbiter in front of one main-memory port: optional victim write-back, then refill.
// Optional feature: define MEMARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module cache_mem_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [1:0]           wb,
    input  logic [PA_WIDTH-1:0]  rd_addr0,
    input  logic [PA_WIDTH-1:0]  rd_addr1,
    input  logic [PA_WIDTH-1:0]  wb_addr0,
    input  logic [PA_WIDTH-1:0]  wb_addr1,
    input  logic [BLK_WIDTH-1:0] wb_blk0,
    input  logic [BLK_WIDTH-1:0] wb_blk1,
    output logic [1:0]           gnt,
    output logic [1:0]           done,
    output logic [BLK_WIDTH-1:0] rd_blk,
    output logic                 mem_wr_en,
    output logic                 mem_rd_en,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic [BLK_WIDTH-1:0] mem_wr_blk,
    input  logic [BLK_WIDTH-1:0] mem_rd_blk,
    input  logic                 mem_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]           r_state;
    logic                 r_owner;
`ifdef MEMARB_FIXED_PRIO_EN
`else
    logic                 r_rr_ptr;
`endif

    logic                 w_win;
    logic                 w_sel;
    logic [PA_WIDTH-1:0]  w_wb_addr;
    logic [PA_WIDTH-1:0]  w_rd_addr;
    logic [BLK_WIDTH-1:0] w_wb_blk;

    // In IDLE the port mux follows the arbitration winner so strobes carry data on state entry.
    always_comb begin
`ifdef MEMARB_FIXED_PRIO_EN
        w_win = ~req[0];
`else
        w_win = (req == 2'b11) ? r_rr_ptr : req[1];
`endif
        w_sel     = (r_state == S_IDLE) ? w_win : r_owner;
        w_wb_addr = w_sel ? wb_addr1 : wb_addr0;
        w_rd_addr = w_sel ? rd_addr1 : rd_addr0;
        w_wb_blk  = w_sel ? wb_blk1  : wb_blk0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
`ifdef MEMARB_FIXED_PRIO_EN
`else
            r_rr_ptr   <= 1'b0;
`endif
            gnt        <= '0;
            done       <= '0;
            rd_blk     <= '0;
            mem_wr_en  <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wr_blk <= '0;
        end else begin
            done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_owner <= w_win;
                        gnt     <= w_win ? 2'b10 : 2'b01;
                        if (wb[w_win]) begin
                            r_state    <= S_WB;
                            mem_wr_en  <= 1'b1;
                            mem_addr   <= w_wb_addr;
                            mem_wr_blk <= w_wb_blk;
                        end else begin
                            r_state   <= S_RD;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= w_rd_addr;
                        end
                    end
                end
                S_WB: begin
                    mem_addr   <= w_wb_addr;
                    mem_wr_blk <= w_wb_blk;
                    if (mem_ack) begin
                        r_state   <= S_RD;
                        mem_wr_en <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= w_rd_addr;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        r_state   <= S_RESP;
                        rd_blk    <= mem_rd_blk;
                        mem_rd_en <= 1'b0;
                        done      <= r_owner ? 2'b10 : 2'b01;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    gnt      <= '0;
`ifdef MEMARB_FIXED_PRIO_EN
`else
                    r_rr_ptr <= ~r_owner;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed reset/miss/arbitration cases, then random misses
// against a transaction-level memory and arbitration model.
module tb_cache_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   wb;
    logic [31:0]  rda [2];
    logic [31:0]  wba [2];
    logic [127:0] wbd [2];
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [127:0] rd_blk;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wr_blk;
    logic [127:0] mem_rd_blk;
    logic         mem_ack;

    int total = 0;
    int bad   = 0;
    int ack_dly = 0;
    int done_cnt [2];

    logic [127:0] mem     [logic [31:0]];
    logic [127:0] ref_mem [logic [31:0]];

    cache_mem_arbiter #(.PA_WIDTH(32), .BLK_WIDTH(128)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wb(wb),
        .rd_addr0(rda[0]), .rd_addr1(rda[1]), .wb_addr0(wba[0]), .wb_addr1(wba[1]),
        .wb_blk0(wbd[0]), .wb_blk1(wbd[1]), .gnt(gnt), .done(done), .rd_blk(rd_blk),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_wr_blk(mem_wr_blk), .mem_rd_blk(mem_rd_blk), .mem_ack(mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_val(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_1111};
    endfunction

    // Arbitration rule: a lone requester wins; a tie goes to the requester not served last.
    function automatic logic [1:0] exp_winner(input logic [1:0] r, input int last);
        if (r == 2'b11) begin
`ifdef MEMARB_FIXED_PRIO_EN
            return 2'b01;
`else
            return (last == 0) ? 2'b10 : 2'b01;
`endif
        end
        return r;
    endfunction

    // Memory responder: acks each strobe after ack_dly (or random 0-7) extra cycles.
    initial begin
        int d;
        mem_ack    = 1'b0;
        mem_rd_blk = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_wr_en || mem_rd_en)) begin
                d = (ack_dly < 0) ? int'($urandom_range(0, 7)) : ack_dly;
                repeat (d) @(negedge clk);
                if (!(rst_n && (mem_wr_en || mem_rd_en))) continue;
                if (mem_wr_en) mem[mem_addr] = mem_wr_blk;
                else mem_rd_blk = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
                mem_ack = 1'b1;
                @(posedge clk);
                #1 mem_ack = 1'b0;
            end
        end
    end

    // Protocol monitor and scoreboard.
    logic [1:0] gnt_prev;
    logic [1:0] req_seen;
    int         outst;
    int         last_srv;
    always @(negedge clk) begin
        int k;
        int o;
        logic [127:0] exp_blk;
        if (!rst_n) begin
            gnt_prev = '0;
            outst    = 0;
            last_srv = 1;
        end else begin
            chk("gnt_onehot", 128'($onehot0(gnt)), 128'(1));
            chk("strobe_excl", 128'(mem_wr_en && mem_rd_en), 128'(0));
            chk("done_owner", 128'((done & ~gnt) != 2'b00), 128'(0));
            if (gnt != 2'b00 && gnt_prev == 2'b00) begin
                chk("grant_order", 128'(gnt), 128'(exp_winner(req_seen, last_srv)));
                chk("grant_overlap", 128'(outst), 128'(0));
                outst = 1;
            end
            if (mem_wr_en || mem_rd_en) chk("strobe_owner", 128'(gnt == 2'b00), 128'(0));
            if (gnt == 2'b01 || gnt == 2'b10) begin
                o = int'(gnt[1]);
                if (mem_wr_en) begin
                    chk("wb_needed", 128'(wb[o]), 128'(1));
                    chk("wb_addr", 128'(mem_addr), 128'(wba[o]));
                    chk("wb_data", mem_wr_blk, wbd[o]);
                end
                if (mem_rd_en) chk("rd_addr", 128'(mem_addr), 128'(rda[o]));
            end
            if (done != 2'b00) begin
                k = int'(done[1]);
                chk("done_once", 128'(outst), 128'(1));
                outst = 0;
                if (wb[k]) ref_mem[wba[k]] = wbd[k];
                exp_blk = ref_mem.exists(rda[k]) ? ref_mem[rda[k]] : init_val(rda[k]);
                chk("rd_data", rd_blk, exp_blk);
                last_srv = k;
                done_cnt[k]++;
            end
            gnt_prev = gnt;
        end
        req_seen = req;
    end

    task automatic do_miss(input int k, input logic w, input logic [31:0] wa, input logic [127:0] wd,
                           input logic [31:0] ra, output int nwr, output int nrd,
                           output logic [31:0] raddr, output logic [127:0] blk, output logic [1:0] dn);
        @(posedge clk);
        #1;
        wb[k] = w; wba[k] = wa; wbd[k] = wd; rda[k] = ra; req[k] = 1'b1;
        nwr = 0; nrd = 0; raddr = '0; blk = '0; dn = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_wr_en) nwr++;
            if (mem_rd_en) begin
                nrd++;
                raddr = mem_addr;
            end
            if (done != 2'b00) begin
                dn  = done;
                blk = rd_blk;
                break;
            end
        end
        @(posedge clk);
        #1 req[k] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr, nrd, ng, nd, tdone, issued, finished;
        int cons [2];
        int gap [2];
        logic act [2];
        logic [31:0]  raddr;
        logic [127:0] blk;
        logic [1:0]   dn, gp, eseq;

        rst_n = 1'b0; req = '0; wb = '0;
        for (int i = 0; i < 2; i++) begin
            rda[i] = '0; wba[i] = '0; wbd[i] = '0; done_cnt[i] = 0;
        end
        mem[32'h1040]     = {16{8'hA5}};
        ref_mem[32'h1040] = {16{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 128'(gnt), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_strobes", 128'({mem_wr_en, mem_rd_en}), 128'(0));
        chk("rst_addr", 128'(mem_addr), 128'(0));
        chk("rst_rd_blk", rd_blk, 128'(0));
        rst_n = 1'b1;

        // Clean miss, ack two cycles after the strobe rises.
        ack_dly = 1;
        do_miss(0, 1'b0, 32'h0, '0, 32'h0000_1040, nwr, nrd, raddr, blk, dn);
        chk("t2_rd_cycles", 128'(nrd), 128'(2));
        chk("t2_wr_cycles", 128'(nwr), 128'(0));
        chk("t2_addr", 128'(raddr), 128'(32'h1040));
        chk("t2_done", 128'(dn), 128'(2'b01));
        chk("t2_blk", blk, {16{8'hA5}});
        @(negedge clk);
        chk("t2_done_len", 128'(done), 128'(0));

        // Dirty miss: write-back then refill.
        ack_dly = 0;
        do_miss(1, 1'b1, 32'h2000, {4{32'h1234_5678}}, 32'h3000, nwr, nrd, raddr, blk, dn);
        chk("t3_wr_cycles", 128'(nwr), 128'(1));
        chk("t3_rd_cycles", 128'(nrd), 128'(1));
        chk("t3_addr", 128'(raddr), 128'(32'h3000));
        chk("t3_done", 128'(dn), 128'(2'b10));
        chk("t3_blk", blk, init_val(32'h3000));
        chk("t3_mem_wb", mem.exists(32'h2000) ? mem[32'h2000] : '0, {4{32'h1234_5678}});

        // Reset asserted while the write strobe is up.
        ack_dly = 7;
        @(posedge clk);
        #1;
        wb[1] = 1'b1; wba[1] = 32'h2100; wbd[1] = {4{32'hCAFE_F00D}}; rda[1] = 32'h2200; req[1] = 1'b1;
        for (int c = 0; c < 10 && !mem_wr_en; c++) @(negedge clk);
        chk("t1_wr_seen", 128'(mem_wr_en), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_gnt", 128'(gnt), 128'(0));
        chk("t1_strobes", 128'({mem_wr_en, mem_rd_en, done}), 128'(0));
        chk("t1_addr", 128'(mem_addr), 128'(0));
        chk("t1_data", mem_wr_blk | rd_blk, 128'(0));
        @(posedge clk);
        #1 req = '0; wb = '0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_idle_gnt", 128'(gnt), 128'(0));
        chk("t1_idle_strobes", 128'({mem_wr_en, mem_rd_en}), 128'(0));

        // Both requests held from reset: four consecutive grants.
        ack_dly = 0;
        @(posedge clk);
        #1;
        rda[0] = 32'h40; rda[1] = 32'h80; req = 2'b11;
        ng = 0; nd = 0; tdone = 0; gp = '0;
        for (int c = 0; c < 200 && nd < 4; c++) begin
            @(negedge clk);
            if (gnt != 2'b00 && gp == 2'b00) begin
`ifdef MEMARB_FIXED_PRIO_EN
                eseq = 2'b01;
`else
                eseq = (ng % 2 == 1) ? 2'b10 : 2'b01;
`endif
                chk("arb_order", 128'(gnt), 128'(eseq));
                if (ng > 0) chk("arb_idle_gap", 128'(c - tdone), 128'(2));
                ng++;
            end
            if (done != 2'b00) begin
                nd++;
                tdone = c;
            end
            gp = gnt;
        end
        @(posedge clk);
        #1 req = '0;
        chk("arb_grants", 128'(ng), 128'(4));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("arb_drop_idle", 128'({gnt, mem_wr_en, mem_rd_en}), 128'(0));
        end

        // Random misses with random ack delays.
        ack_dly = -1;
        issued = 0; finished = 0;
        for (int k = 0; k < 2; k++) begin
            cons[k] = done_cnt[k]; gap[k] = 0; act[k] = 1'b0;
        end
        for (int c = 0; c < 20000 && finished < 200; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (act[k]) begin
                    if (done_cnt[k] != cons[k]) begin
                        cons[k] = done_cnt[k];
                        req[k] = 1'b0;
                        act[k] = 1'b0;
                        finished++;
                        gap[k] = int'($urandom_range(0, 3));
                    end
                end else if (issued < 200) begin
                    if (gap[k] == 0) begin
                        rda[k] = 32'($urandom_range(0, 15)) << 4;
                        wba[k] = 32'($urandom_range(0, 15)) << 4;
                        wbd[k] = {$urandom, $urandom, $urandom, $urandom};
                        wb[k]  = 1'($urandom_range(0, 1));
                        req[k] = 1'b1;
                        act[k] = 1'b1;
                        issued++;
                    end else begin
                        gap[k]--;
                    end
                end
            end
        end
        chk("rand_complete", 128'(finished), 128'(200));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
